// File: rtl/register_pkg.sv
// Datapath constants shared by every register in the 8-bit computer, so all
// A/B/output registers agree on word size and reset contents.
package register_pkg;

  localparam int DATA_WIDTH = 8;
  localparam logic [DATA_WIDTH-1:0] REG_RESET_VALUE = 8'h00;

endpackage : register_pkg

// File: rtl/register_dff_en.sv
// Single-bit D flip-flop with load enable and asynchronous active-low reset.
// A non-1 enable (0, X or Z) falls through to hold, so it never loads.
module dff_en #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_BIT;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule : dff_en

// File: rtl/register.sv
// WIDTH-bit load-enabled data register built from one dff_en per bit; value is
// driven purely from the flops, with no combinational path from in.
module register
  import register_pkg::*;
#(
  parameter int               WIDTH       = DATA_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(REG_RESET_VALUE)
) (
  input  logic [WIDTH-1:0] in,
  input  logic             clk,
  input  logic             enable,
  input  logic             reset,
  output logic [WIDTH-1:0] value
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_en #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_dff (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .d      (in[i]),
      .q      (value[i])
    );
  end

endmodule : register

// File: tb/tb_register.sv
// Self-checking bench for register: a reference model pushes the expected
// word before each clock edge and the scoreboard pops and compares after it.
module tb_register;
  import register_pkg::*;

  localparam int W = DATA_WIDTH;

  logic [W-1:0] in;
  logic         clk;
  logic         enable;
  logic         reset;
  logic [W-1:0] value;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_val;
  int           n_checks;
  int           n_pass;

  register dut (
    .in     (in),
    .clk    (clk),
    .enable (enable),
    .reset  (reset),
    .value  (value)
  );

  // Clock and reset: rising edges at t=5,15,25,...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #90000;
    $display("FAIL watchdog: time limit reached, got no summary, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%02h expected 0x%02h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: reset wins, otherwise only an enable of exactly 1 loads.
  task automatic cycle(input string tag);
    logic [W-1:0] exp;
    if (reset !== 1'b1) model_val = REG_RESET_VALUE;
    else if (enable === 1'b1) model_val = in;
    exp_q.push_back(model_val);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, value, model_val);
    end else begin
      exp = exp_q.pop_front();
      check(tag, value, exp);
    end
  endtask

  // Asserts reset between edges and checks the clear without waiting for clk.
  task automatic async_reset(input string tag, input bit release_after);
    reset = 1'b0;
    #1;
    model_val = REG_RESET_VALUE;
    check(tag, value, REG_RESET_VALUE);
    if (release_after) reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_val = REG_RESET_VALUE;
    reset  = 1'b0;
    enable = 1'b1;
    in     = 8'h0F;
    #1;
    check("reset_initial", value, 8'h00);

    cycle("reset_edge5");
    cycle("reset_edge15");
    #1; reset = 1'b1;                 // t=17
    cycle("load_0f_after_release");
    #1; in = 8'h0A;                   // t=27
    cycle("load_0a");
    #1; enable = 1'b0;                // t=37
    cycle("hold_edge45");
    #1; in = 8'h05;                   // t=47
    cycle("hold_edge55");
    #1; enable = 1'b1;                // t=57
    cycle("load_05");                 // t=66 after this
    check("load_05_direct", value, 8'h05);

    #6;                               // t=72, between edges
    async_reset("async_clear_midcycle", 1'b0);
    enable = 1'b1;
    in = 8'hFF;
    cycle("reset_beats_enable");
    check("reset_beats_enable_direct", value, 8'h00);
    #1; reset = 1'b1;
    cycle("load_ff_after_release");

    // in toggling between edges must not reach value.
    #1; in = 8'h3C;
    #2; check("no_comb_path", value, 8'hFF);
    in = 8'hC3;
    #1; check("no_comb_path_2", value, 8'hFF);
    cycle("load_c3");

    // Non-1 enable must hold.
    #1; enable = 1'bx; in = 8'h99;
    cycle("x_enable_holds");
    #1; enable = 1'b1;
    cycle("load_99");

    for (int i = 0; i < 40; i++) begin
      #1;
      in     = W'($urandom_range(0, 255));
      enable = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) async_reset("rand_async_clear", 1'b1);
      cycle("rand_cycle");
    end

    in = 8'hA5; enable = 1'b1;
    cycle("load_a5");
    #2;
    async_reset("async_clear_final", 1'b0);

    if (exp_q.size() != 0) check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_register
